alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
Shares one combinational 4-bit ALU between two requesters, each using a valid/ready request channel and a valid/ready response channel. A 3-state FSM does the work:
- round-robin arbitration between the requesters;
- captures the winner's operands and drives the ALU from registers;
- samples the result and flags, then holds the response until it is accepted.
It sits between on-chip requesters and the ALU instance, in the chip-level top wrapper.

Parameters:
WIDTH, 4, operand/result width (ALU datapath width)
SEL_W, 4, ALU operation select width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester request valid; bit i = requester i
req_ready  out  2  per-requester request accept; combinational from state and req_valid
req0_a, req0_b  in  WIDTH each  requester 0 operands
req0_sel  in  SEL_W  requester 0 ALU op
req1_a, req1_b  in  WIDTH each  requester 1 operands
req1_sel  in  SEL_W  requester 1 ALU op
alu_a, alu_b  out  WIDTH each  registered ALU operands
alu_sel  out  SEL_W  registered ALU select
alu_result  in  WIDTH  ALU result
alu_flags  in  4  ALU flags {carry, zero, negative, overflow}
rsp_valid  out  2  per-requester response valid, at most one bit set
rsp_ready  in  2  per-requester response accept
rsp_data  out  WIDTH  registered result, shared by both requesters
rsp_flags  out  4  registered flags, shared, same order as alu_flags

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, alu_a/alu_b/alu_sel=0, rsp_valid=0, rsp_data=0, rsp_flags=0, last_grant=1 (so requester 0 wins the first tie). req_ready=0 whenever state != IDLE.
- Reset mid-operation aborts the op. The captured request is dropped with no response, and the requester must re-issue.
- Interface rules:
  - req_valid must not depend on req_ready.
  - Once req_valid is asserted, operands are held stable until accepted.
  - Requesters may deassert req_valid before acceptance.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally.
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - req_ready[winner]=1 and the other bit is 0.
  - On a handshake, latch the winner's a/b/sel into alu_a/alu_b/alu_sel, record grant_id=winner, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (one cycle): the ALU settles on the registered operands. At the end of the cycle, register alu_result into rsp_data and alu_flags into rsp_flags, set rsp_valid[grant_id]=1, go to RESP.
- RESP:
  - rsp_valid[grant_id] held, with rsp_data and rsp_flags stable, until rsp_ready[grant_id]=1.
  - On handshake: rsp_valid cleared, last_grant=grant_id, go to IDLE.
  - rsp_ready of the non-granted requester is ignored. An indefinite stall is allowed, and new requests wait.
- Latency: request handshake in cycle T; rsp_valid high from cycle T+2. Minimum initiation interval is 3 cycles per op, achieved when rsp_ready is already high at T+2.
- alu_a/alu_b/alu_sel keep their last values outside EXEC (no glitching to 0).
- Widths: pure pass-through, no arithmetic in this block; flags are taken verbatim from the ALU.

Optional Feature:
Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins a tie. last_grant is not implemented.
- Undefined (default): round-robin as specified above.
- All other timing is identical in both builds.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum type (IDLE, EXEC, RESP);
  - flag bit index constants FLG_C=3, FLG_Z=2, FLG_N=1, FLG_V=0;
  - op code constants ALU_OP_ADD=4'h0, ALU_OP_SUB=4'h1, matching the team's ALU encoding.
- One sub-module is natural: alu_rr_grant2, the 2-way round-robin/fixed-priority grant logic.

Test Plan:
- Single op, req0 a=3, b=5, sel=ADD, rsp_ready=1 -> rsp_valid[0] at T+2, rsp_data=8, rsp_flags=4'b0011, rsp_valid[1] stays 0.
- Carry/zero, req1 a=9, b=7, sel=ADD -> rsp_valid[1], rsp_data=0, rsp_flags=4'b1100.
- Both valid every cycle for 4 ops, default build -> grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN -> all four ops go to requester 0.
- Backpressure: rsp_ready[0]=0 for 10 cycles while req1 is valid -> rsp_data and rsp_flags stable, req_ready=0; req1 granted in IDLE after rsp_ready[0] rises.
- rst pulse during EXEC -> next cycle all outputs at reset values, no rsp_valid; a re-issued request completes normally.
- Request withdrawn: req_valid[0] pulsed during the RESP of another op and dropped before IDLE -> no grant to requester 0, FSM stays IDLE.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Bit positions inside the 4-bit {carry, zero, negative, overflow} flag word
    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_V = 0;

    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester, ALU and response signals of the arbiter grouped as one bundle.
interface alu_req_arbiter_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SEL_W = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [SEL_W-1:0] req0_sel;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [SEL_W-1:0] req1_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;

    // Arbiter side
    modport slave (
        input  req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel,
        input  alu_result, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_flags
    );

    // Requesters and ALU side
    modport master (
        output req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel,
        output alu_result, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_flags
    );

endinterface

// File: rtl/alu_req_arbiter_grant.sv
// Two-way grant: round-robin on ties, or fixed priority to requester 0
// when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_grant2 (
    input  logic [1:0] req_valid_i,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic       last_grant_i,
`endif
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |req_valid_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_id_o = ~req_valid_i[0];
`else
        if (&req_valid_i) begin
            gnt_id_o = ~last_grant_i;
        end else begin
            gnt_id_o = req_valid_i[1];
        end
`endif
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters via an
// IDLE/EXEC/RESP FSM. Define ALU_ARB_FIXED_PRIO_EN for fixed-priority ties.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SEL_W = 4
) (
    input logic              clk,
    input logic              rst,
    alu_req_arbiter_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             grant_id_q, grant_id_d;
    logic             gnt_valid;
    logic             gnt_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;
`endif

    alu_rr_grant2 u_grant (
        .req_valid_i  (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .last_grant_i (last_grant_q),
`endif
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            grant_id_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
            grant_id_q   <= grant_id_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        grant_id_d   = grant_id_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                // req_ready is raised for the winner whenever any request is valid,
                // so a valid grant is always a completed handshake.
                if (gnt_valid) begin
                    state_d    = EXEC;
                    grant_id_d = gnt_id;
                    alu_a_d    = gnt_id ? bus.req1_a   : bus.req0_a;
                    alu_b_d    = gnt_id ? bus.req1_b   : bus.req0_b;
                    alu_sel_d  = gnt_id ? bus.req1_sel : bus.req0_sel;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_data_d  = bus.alu_result;
                rsp_flags_d = bus.alu_flags;
            end
            RESP: begin
                if (bus.rsp_ready[grant_id_q]) begin
                    state_d      = IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = grant_id_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state_q == IDLE && gnt_valid) begin
            bus.req_ready = onehot2(gnt_id);
        end
        if (state_q == RESP) begin
            bus.rsp_valid = onehot2(grant_id_q);
        end
        bus.alu_a     = alu_a_q;
        bus.alu_b     = alu_b_q;
        bus.alu_sel   = alu_sel_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_flags = rsp_flags_q;
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a small ADD/SUB ALU model.
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [4:0] alu_ext;

    alu_req_arbiter_if #(.WIDTH(4), .SEL_W(4)) bus ();

    alu_req_arbiter #(.WIDTH(4), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: ADD and SUB with {C,Z,N,V} flags
    always_comb begin
        alu_ext        = '0;
        bus.alu_result = '0;
        bus.alu_flags  = '0;
        if (bus.alu_sel == ALU_OP_SUB) begin
            alu_ext = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            bus.alu_result = alu_ext[3:0];
            bus.alu_flags[FLG_C] = ~alu_ext[4];
            bus.alu_flags[FLG_V] = (bus.alu_a[3] != bus.alu_b[3]) && (alu_ext[3] != bus.alu_a[3]);
        end else begin
            alu_ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_result = alu_ext[3:0];
            bus.alu_flags[FLG_C] = alu_ext[4];
            bus.alu_flags[FLG_V] = (bus.alu_a[3] == bus.alu_b[3]) && (alu_ext[3] != bus.alu_a[3]);
        end
        bus.alu_flags[FLG_Z] = (alu_ext[3:0] == 4'd0);
        bus.alu_flags[FLG_N] = alu_ext[3];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (bus.alu_a !== 4'd0) begin fails++; $display("FAIL reset_alu_a: got %h expected 0", bus.alu_a); end
        tests++; if (bus.alu_b !== 4'd0) begin fails++; $display("FAIL reset_alu_b: got %h expected 0", bus.alu_b); end
        tests++; if (bus.alu_sel !== 4'd0) begin fails++; $display("FAIL reset_alu_sel: got %h expected 0", bus.alu_sel); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 4'd0) begin fails++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
        tests++; if (bus.rsp_flags !== 4'd0) begin fails++; $display("FAIL reset_rsp_flags: got %b expected 0000", bus.rsp_flags); end
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready_idle: got %b expected 00", bus.req_ready); end
        bus.req_valid = 2'b11;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL reset_first_tie: got %b expected 01", bus.req_ready); end
        bus.req_valid = 2'b00;
        #1;
    endtask

    task automatic test_single_op();
        bus.rsp_ready = 2'b11;
        bus.req0_a = 4'd3; bus.req0_b = 4'd5; bus.req0_sel = ALU_OP_ADD;
        bus.req_valid = 2'b01;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_req_ready: got %b expected 01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL single_exec_ready: got %b expected 00", bus.req_ready); end
        tests++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 12'h350) begin fails++; $display("FAIL single_alu_ops: got %h expected 350", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL single_exec_rsp: got %b expected 00", bus.rsp_valid); end
        step();
        tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL single_rsp_valid: got %b expected 01", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 4'd8) begin fails++; $display("FAIL single_rsp_data: got %0d expected 8", bus.rsp_data); end
        tests++; if (bus.rsp_flags !== 4'b0011) begin fails++; $display("FAIL single_rsp_flags: got %b expected 0011", bus.rsp_flags); end
        step();
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL single_rsp_clear: got %b expected 00", bus.rsp_valid); end
    endtask

    task automatic test_carry_zero();
        bus.req1_a = 4'd9; bus.req1_b = 4'd7; bus.req1_sel = ALU_OP_ADD;
        bus.req_valid = 2'b10;
        #1;
        tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL cz_req_ready: got %b expected 10", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        step();
        tests++; if (bus.rsp_valid !== 2'b10) begin fails++; $display("FAIL cz_rsp_valid: got %b expected 10", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 4'd0) begin fails++; $display("FAIL cz_rsp_data: got %0d expected 0", bus.rsp_data); end
        tests++; if (bus.rsp_flags !== 4'b1100) begin fails++; $display("FAIL cz_rsp_flags: got %b expected 1100", bus.rsp_flags); end
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        logic [3:0] exp_data;
        bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_sel = ALU_OP_ADD;
        bus.req1_a = 4'd4; bus.req1_b = 4'd2; bus.req1_sel = ALU_OP_ADD;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_gnt = 2'b01;
`else
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_data = (exp_gnt == 2'b01) ? 4'd2 : 4'd6;
            #1;
            tests++; if (bus.req_ready !== exp_gnt) begin fails++; $display("FAIL rr_grant_%0d: got %b expected %b", i, bus.req_ready, exp_gnt); end
            step();
            step();
            tests++; if (bus.rsp_valid !== exp_gnt) begin fails++; $display("FAIL rr_rsp_valid_%0d: got %b expected %b", i, bus.rsp_valid, exp_gnt); end
            tests++; if (bus.rsp_data !== exp_data) begin fails++; $display("FAIL rr_rsp_data_%0d: got %0d expected %0d", i, bus.rsp_data, exp_data); end
            step();
        end
        bus.req_valid = 2'b00;
        #1;
    endtask

    task automatic test_backpressure();
        bus.req0_a = 4'd15; bus.req0_b = 4'd15; bus.req0_sel = ALU_OP_ADD;
        bus.req1_a = 4'd1;  bus.req1_b = 4'd2;  bus.req1_sel = ALU_OP_ADD;
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b11;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL bp_first_grant: got %b expected 01", bus.req_ready); end
        step();
        bus.req_valid = 2'b10;
        step();
        for (int i = 0; i < 10; i++) begin
            tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL bp_hold_valid_%0d: got %b expected 01", i, bus.rsp_valid); end
            tests++; if (bus.rsp_data !== 4'd14) begin fails++; $display("FAIL bp_hold_data_%0d: got %0d expected 14", i, bus.rsp_data); end
            tests++; if (bus.rsp_flags !== 4'b1010) begin fails++; $display("FAIL bp_hold_flags_%0d: got %b expected 1010", i, bus.rsp_flags); end
            tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL bp_hold_ready_%0d: got %b expected 00", i, bus.req_ready); end
            step();
        end
        bus.rsp_ready = 2'b11;
        step();
        tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL bp_req1_grant: got %b expected 10", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        step();
        tests++; if (bus.rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_req1_rsp_valid: got %b expected 10", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 4'd3) begin fails++; $display("FAIL bp_req1_rsp_data: got %0d expected 3", bus.rsp_data); end
        tests++; if (bus.rsp_flags !== 4'b0000) begin fails++; $display("FAIL bp_req1_rsp_flags: got %b expected 0000", bus.rsp_flags); end
        step();
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL bp_done: got %b expected 00", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid_op();
        bus.req0_a = 4'd5; bus.req0_b = 4'd6; bus.req0_sel = ALU_OP_SUB;
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        tests++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 12'h561) begin fails++; $display("FAIL rst_exec_ops: got %h expected 561", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 12'h000) begin fails++; $display("FAIL rst_mid_ops: got %h expected 000", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        tests++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_flags} !== 10'd0) begin fails++; $display("FAIL rst_mid_rsp: got %h expected 000", {bus.rsp_valid, bus.rsp_data, bus.rsp_flags}); end
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL rst_mid_ready: got %b expected 00", bus.req_ready); end
        step();
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL rst_no_rsp: got %b expected 00", bus.rsp_valid); end
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        step();
        tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL rst_reissue_valid: got %b expected 01", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 4'd15) begin fails++; $display("FAIL rst_reissue_data: got %0d expected 15", bus.rsp_data); end
        tests++; if (bus.rsp_flags !== 4'b0010) begin fails++; $display("FAIL rst_reissue_flags: got %b expected 0010", bus.rsp_flags); end
        step();
    endtask

    task automatic test_withdraw();
        bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_sel = ALU_OP_ADD;
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        step();
        bus.req0_a = 4'd7; bus.req0_b = 4'd1; bus.req0_sel = ALU_OP_ADD;
        bus.req_valid = 2'b01;
        #1;
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL wd_resp_ready: got %b expected 00", bus.req_ready); end
        step();
        tests++; if (bus.rsp_valid !== 2'b10) begin fails++; $display("FAIL wd_rsp_valid: got %b expected 10", bus.rsp_valid); end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b10;
        step();
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL wd_idle_ready: got %b expected 00", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL wd_idle_rsp: got %b expected 00", bus.rsp_valid); end
        step();
        step();
        tests++; if ({bus.alu_a, bus.alu_b} !== 8'h22) begin fails++; $display("FAIL wd_no_capture: got %h expected 22", {bus.alu_a, bus.alu_b}); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL wd_still_idle: got %b expected 00", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 4'd4) begin fails++; $display("FAIL wd_data_hold: got %0d expected 4", bus.rsp_data); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
        test_reset();
        test_single_op();
        test_carry_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
